// File: rtl/hub75_bcm_driver.sv
// HUB75 LED-matrix driver with binary-code-modulation colour depth.
// Shifts one bitplane per row pair, latches it, then lights it for BASE_ON<<plane clocks.
module hub75_bcm_driver #(
  parameter int COLS         = 32,
  parameter int ROW_BITS     = 4,
  parameter int DEPTH        = 4,
  parameter int BASE_ON      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [3*DEPTH-1:0]       pix_rgb1,
  input  logic [3*DEPTH-1:0]       pix_rgb2,
  output logic [$clog2(COLS)-1:0]  pix_col,
  output logic [ROW_BITS-1:0]      pix_row,
  output logic                     frame_start,
  output logic [2:0]               RGB1,
  output logic [2:0]               RGB2,
  output logic [ROW_BITS-1:0]      rowD,
  output logic                     SCLK,
  output logic                     LAT,
  output logic                     OE
);

  localparam int CB        = $clog2(COLS);
  localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SHIFT_LEN = 2 * COLS + 2;
  localparam int MAX_ON    = BASE_ON << (DEPTH - 1);
  localparam int CW_ON     = $clog2(MAX_ON) + 1;
  localparam int CW_SH     = $clog2(SHIFT_LEN) + 1;
  localparam int CW_BL     = $clog2(BLANK_CYCLES + 1) + 1;
  localparam int CW_A      = (CW_ON > CW_SH) ? CW_ON : CW_SH;
  localparam int CW        = (CW_A > CW_BL) ? CW_A : CW_BL;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_BLANK   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_DISPLAY = 3'd4
  } state_t;

  state_t                state_r, state_n;
  logic [CW-1:0]         cnt_r, cnt_n;
  logic [ROW_BITS-1:0]   row_r, row_n;
  logic [PW-1:0]         plane_r, plane_n;
  logic [CW-1:0]         dlen_s;

  logic [CB-1:0]         pix_col_r, pix_col_s;
  logic [ROW_BITS-1:0]   pix_row_r, rowd_r, rowd_s;
  logic                  frame_start_r, frame_start_s;
  logic [2:0]            rgb1_r, rgb1_s, rgb2_r, rgb2_s;
  logic                  sclk_r, sclk_s, lat_r, lat_s, oe_r, oe_s;
  logic [3*DEPTH-1:0]    sh1_s, sh2_s;

  assign dlen_s = CW'(BASE_ON) << plane_r;
  assign sh1_s  = pix_rgb1 >> plane_r;
  assign sh2_s  = pix_rgb2 >> plane_r;

  // State register plus registered copies of every panel/RAM output
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CW{1'b0}};
      row_r         <= {ROW_BITS{1'b0}};
      plane_r       <= {PW{1'b0}};
      pix_col_r     <= {CB{1'b0}};
      pix_row_r     <= {ROW_BITS{1'b0}};
      rowd_r        <= {ROW_BITS{1'b0}};
      frame_start_r <= 1'b0;
      rgb1_r        <= 3'b000;
      rgb2_r        <= 3'b000;
      sclk_r        <= 1'b0;
      lat_r         <= 1'b0;
      oe_r          <= 1'b1;
    end else begin
      state_r       <= state_n;
      cnt_r         <= cnt_n;
      row_r         <= row_n;
      plane_r       <= plane_n;
      pix_col_r     <= pix_col_s;
      pix_row_r     <= row_n;
      rowd_r        <= rowd_s;
      frame_start_r <= frame_start_s;
      rgb1_r        <= rgb1_s;
      rgb2_r        <= rgb2_s;
      sclk_r        <= sclk_s;
      lat_r         <= lat_s;
      oe_r          <= oe_s;
    end
  end

  // Next-state, counters and row/plane sequencing
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r + CW'(1'b1);
    row_n   = row_r;
    plane_n = plane_r;
    case (state_r)
      ST_IDLE: begin
        cnt_n   = {CW{1'b0}};
        row_n   = {ROW_BITS{1'b0}};
        plane_n = {PW{1'b0}};
        if (enable) state_n = ST_SHIFT;
        else        state_n = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cnt_r == CW'(SHIFT_LEN - 1)) begin
          state_n = ST_BLANK;
          cnt_n   = {CW{1'b0}};
        end else begin
          state_n = ST_SHIFT;
        end
      end
      ST_BLANK: begin
        if (cnt_r == CW'(BLANK_CYCLES - 1)) begin
          state_n = ST_LATCH;
          cnt_n   = {CW{1'b0}};
        end else begin
          state_n = ST_BLANK;
        end
      end
      ST_LATCH: begin
        state_n = ST_DISPLAY;
        cnt_n   = {CW{1'b0}};
      end
      ST_DISPLAY: begin
        if (cnt_r == dlen_s - CW'(1'b1)) begin
          cnt_n = {CW{1'b0}};
          if (!enable) begin
            state_n = ST_IDLE;
            row_n   = {ROW_BITS{1'b0}};
            plane_n = {PW{1'b0}};
          end else if (plane_r < PW'(DEPTH - 1)) begin
            state_n = ST_SHIFT;
            plane_n = plane_r + PW'(1'b1);
          end else begin
            state_n = ST_SHIFT;
            plane_n = {PW{1'b0}};
            row_n   = row_r + ROW_BITS'(1'b1);
          end
        end else begin
          state_n = ST_DISPLAY;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = {CW{1'b0}};
        row_n   = {ROW_BITS{1'b0}};
        plane_n = {PW{1'b0}};
      end
    endcase
  end

  // Output values for the cycle being entered; the RAM word read for column c
  // is captured entering cycle 2c+2 and held through the SCLK-high cycle 2c+3.
  always_comb begin
    oe_s          = 1'b1;
    lat_s         = 1'b0;
    sclk_s        = 1'b0;
    rgb1_s        = 3'b000;
    rgb2_s        = 3'b000;
    pix_col_s     = {CB{1'b0}};
    rowd_s        = rowd_r;
    frame_start_s = 1'b0;
    case (state_n)
      ST_SHIFT: begin
        if (cnt_n < CW'(2 * COLS)) pix_col_s = cnt_n[CB:1];
        else                       pix_col_s = {CB{1'b0}};
        if (cnt_n >= CW'(2)) begin
          if (cnt_n[0]) begin
            sclk_s = 1'b1;
            rgb1_s = rgb1_r;
            rgb2_s = rgb2_r;
          end else begin
            rgb1_s = {sh1_s[2*DEPTH], sh1_s[DEPTH], sh1_s[0]};
            rgb2_s = {sh2_s[2*DEPTH], sh2_s[DEPTH], sh2_s[0]};
          end
        end else begin
          sclk_s = 1'b0;
        end
        if (state_r != ST_SHIFT && row_n == {ROW_BITS{1'b0}} && plane_n == {PW{1'b0}})
          frame_start_s = 1'b1;
        else
          frame_start_s = 1'b0;
      end
      ST_LATCH: begin
        lat_s  = 1'b1;
        rowd_s = row_n;
      end
      ST_DISPLAY: oe_s = 1'b0;
      default:    oe_s = 1'b1;
    endcase
  end

  assign pix_col     = pix_col_r;
  assign pix_row     = pix_row_r;
  assign frame_start = frame_start_r;
  assign RGB1        = rgb1_r;
  assign RGB2        = rgb2_r;
  assign rowD        = rowd_r;
  assign SCLK        = sclk_r;
  assign LAT         = lat_r;
  assign OE          = oe_r;

endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Directed bench for hub75_bcm_driver at default parameters: a negedge monitor
// records panel activity and the linear sequence below checks it.
module tb_hub75_bcm_driver;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] pix_rgb1, pix_rgb2;
  logic [4:0]  pix_col;
  logic [3:0]  pix_row, rowD;
  logic        frame_start, SCLK, LAT, OE;
  logic [2:0]  RGB1, RGB2;

  int checks = 0;
  int failures = 0;

  hub75_bcm_driver dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pix_rgb1(pix_rgb1), .pix_rgb2(pix_rgb2),
    .pix_col(pix_col), .pix_row(pix_row), .frame_start(frame_start),
    .RGB1(RGB1), .RGB2(RGB2), .rowD(rowD),
    .SCLK(SCLK), .LAT(LAT), .OE(OE)
  );

  always #5 clk = ~clk;

  // Frame buffer: one-clock read latency; colmode puts pix_col[0] into R[0] of the lower half
  logic [11:0] pat1 = 12'hFFF;
  logic [11:0] pat2 = 12'hFFF;
  logic        colmode = 1'b0;
  always @(posedge clk) begin
    pix_rgb1 <= pat1;
    pix_rgb2 <= colmode ? {3'b000, pix_col[0], 8'h00} : pat2;
  end

  // Panel monitor
  int cyc = 0, sclk_total = 0, sclk_since = 0, run = 0, last_sclk_cyc = 0;
  int bad_sclk_lit = 0, bad_lat_lit = 0, bad_rgb_hold = 0;
  logic [2:0]  or1 = 3'b000, and1 = 3'b111, and2 = 3'b111, prev1 = 3'b000, prev2 = 3'b000;
  logic [31:0] r2bits = 32'h0;
  int lat_cyc_q[$], lat_row_q[$], lat_sclk_q[$], width_q[$], fs_cyc_q[$];
  logic [2:0]  lat_or1_q[$], lat_and1_q[$], lat_and2_q[$];
  logic [31:0] lat_r2_q[$];

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      sclk_since = 0; or1 = 3'b000; and1 = 3'b111; and2 = 3'b111; r2bits = 32'h0; run = 0;
    end else begin
      if (SCLK) begin
        sclk_total++; sclk_since++; last_sclk_cyc = cyc;
        or1 = or1 | RGB1; and1 = and1 & RGB1; and2 = and2 & RGB2;
        r2bits = {r2bits[30:0], RGB2[2]};
        if (RGB1 !== prev1 || RGB2 !== prev2) bad_rgb_hold++;
        if (OE !== 1'b1) bad_sclk_lit++;
      end
      if (LAT) begin
        if (OE !== 1'b1) bad_lat_lit++;
        lat_cyc_q.push_back(cyc); lat_row_q.push_back(int'(rowD)); lat_sclk_q.push_back(sclk_since);
        lat_or1_q.push_back(or1); lat_and1_q.push_back(and1); lat_and2_q.push_back(and2);
        lat_r2_q.push_back(r2bits);
        sclk_since = 0; or1 = 3'b000; and1 = 3'b111; and2 = 3'b111; r2bits = 32'h0;
      end
      if (frame_start) fs_cyc_q.push_back(cyc);
      if (OE === 1'b0) run++;
      else if (run > 0) begin
        width_q.push_back(run);
        run = 0;
      end
    end
    prev1 = RGB1; prev2 = RGB2;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_lats(input int n, input string tag);
    for (int i = 0; i < 20000 && lat_row_q.size() < n; i++) step();
    chk(tag, longint'(lat_row_q.size() >= n), 1);
  endtask

  task automatic wait_widths(input int n, input string tag);
    for (int i = 0; i < 20000 && width_q.size() < n; i++) step();
    chk(tag, longint'(width_q.size() >= n), 1);
  endtask

  initial begin
    int errs, base, wb, s0, n0, n1;
    logic [2:0] exp_rgb;

    // Reset state
    repeat (3) step();
    chk("rst_oe", OE, 1);
    chk("rst_lat", LAT, 0);
    chk("rst_sclk", SCLK, 0);
    chk("rst_rgb1", RGB1, 0);
    chk("rst_rgb2", RGB2, 0);
    chk("rst_rowd", rowD, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_col", pix_col, 0);
    chk("rst_row", pix_row, 0);

    // First plane with all-ones pixels
    reset = 1'b0; enable = 1'b1;
    step();
    chk("fs_pulse", frame_start, 1);
    chk("fs_oe", OE, 1);
    step();
    chk("fs_one_clk", frame_start, 0);
    wait_lats(1, "first_lat_timeout");
    chk("first_sclks", lat_sclk_q[0], 32);
    chk("first_rgb1", lat_and1_q[0], 7);
    chk("first_rgb2", lat_and2_q[0], 7);
    chk("shift_to_lat", lat_cyc_q[0] - fs_cyc_q[0], 68);
    chk("blank_clks", lat_cyc_q[0] - last_sclk_cyc - 1, 2);
    wait_widths(1, "first_on_timeout");
    chk("first_on", width_q[0], 8);

    // Free-run a whole frame plus the wrap back to row 0
    wait_lats(65, "frame_timeout");
    errs = 0;
    for (int i = 0; i < 64; i++) if (width_q[i] != (8 << (i % 4))) errs++;
    chk("bcm_widths", errs, 0);
    errs = 0;
    for (int i = 0; i < 65; i++) if (lat_row_q[i] != (i / 4) % 16) errs++;
    chk("row_seq", errs, 0);
    chk("wrap_row0", lat_row_q[64], 0);
    chk("wrap_fs_count", fs_cyc_q.size(), 2);
    chk("wrap_fs_cycle", fs_cyc_q[1], lat_cyc_q[64] - 68);
    chk("sclk_total", sclk_total, 65 * 32);
    chk("sclk_while_lit", bad_sclk_lit, 0);
    chk("lat_while_lit", bad_lat_lit, 0);
    chk("rgb_moves_at_sclk", bad_rgb_hold, 0);

    // Bitplane selection: R=0101 upper, column-alternating R[0] lower
    reset = 1'b1; enable = 1'b0;
    repeat (2) step();
    pat1 = 12'h500; colmode = 1'b1;
    reset = 1'b0; enable = 1'b1;
    base = lat_row_q.size();
    wait_lats(base + 4, "planes_timeout");
    for (int p = 0; p < 4; p++) begin
      exp_rgb = (p % 2 == 0) ? 3'b100 : 3'b000;
      chk($sformatf("plane%0d_rgb1_or", p), lat_or1_q[base + p], exp_rgb);
      chk($sformatf("plane%0d_rgb1_and", p), lat_and1_q[base + p], exp_rgb);
      chk($sformatf("plane%0d_rgb2_cols", p), lat_r2_q[base + p], (p == 0) ? 32'h55555555 : 32'h0);
    end
    pat1 = 12'hFFF; colmode = 1'b0;

    // Disable in the middle of row 1, plane 2
    wait_lats(base + 7, "row1_timeout");
    for (int i = 0; i < 2000 && OE !== 1'b0; i++) step();
    chk("disp_reached", OE, 0);
    repeat (3) step();
    wb = width_q.size();
    enable = 1'b0;
    wait_widths(wb + 1, "disable_timeout");
    chk("disable_full_width", width_q[wb], 32);
    chk("disable_row", lat_row_q[base + 6], 1);
    s0 = sclk_total; n0 = lat_row_q.size();
    repeat (100) step();
    chk("idle_no_sclk", sclk_total, s0);
    chk("idle_no_lat", lat_row_q.size(), n0);
    chk("idle_oe", OE, 1);
    chk("idle_no_light", width_q.size(), wb + 1);
    enable = 1'b1;
    step();
    chk("reenable_fs", frame_start, 1);
    wait_lats(n0 + 1, "reenable_timeout");
    chk("reenable_row0", lat_row_q[n0], 0);
    wait_widths(wb + 2, "reenable_on_timeout");
    chk("reenable_plane0", width_q[wb + 1], 8);

    // Reset at shift cycle 10 of the next plane (first cycle with pix_col=5)
    for (int i = 0; i < 2000 && pix_col != 5'd5; i++) step();
    chk("shift_k10_col", pix_col, 5);
    chk("shift_k10_rgb", RGB1, 7);
    reset = 1'b1;
    step();
    chk("abort_sclk", SCLK, 0);
    chk("abort_oe", OE, 1);
    chk("abort_rgb1", RGB1, 0);
    chk("abort_rgb2", RGB2, 0);
    chk("abort_col", pix_col, 0);
    reset = 1'b0;
    step();
    chk("restart_fs", frame_start, 1);
    n1 = lat_row_q.size();
    wb = width_q.size();
    wait_lats(n1 + 1, "restart_timeout");
    chk("restart_row0", lat_row_q[n1], 0);
    chk("restart_sclks", lat_sclk_q[n1], 32);
    wait_widths(wb + 1, "restart_on_timeout");
    chk("restart_plane0", width_q[wb], 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
